wb_unit: RTL and testbench
==========================

# wb_unit

Write-back unit of the multi-cycle NPC core. Accepts one retired instruction from the EXU per valid/ready handshake. For loads it also waits for the bus read response from the LSU and aligns and sign-extends the data. It then drives the register file write port (gpr_wen / rd_id / rd) for exactly one commit cycle and signals commit, with the next PC, to the IFU.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESP_OKAY, 2'b00, bus response code meaning success

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_exu_valid  in  1  EXU offers an instruction
- o_exu_ready  out  1  WBU can accept
- i_exu_wen  in  1  instruction writes a GPR
- i_exu_rd_id  in  5  destination register
- i_exu_is_load  in  1  result comes from the LSU, not i_exu_result
- i_exu_ld_funct3  in  3  load type (funct3 encoding)
- i_exu_addr_lo  in  2  load address bits [1:0]
- i_exu_result  in  XLEN  ALU/CSR/link result
- i_exu_pc_next  in  XLEN  PC of next instruction
- i_lsu_rvalid  in  1  load data valid
- o_lsu_rready  out  1  WBU accepts load data
- i_lsu_rdata  in  32  raw aligned word from bus
- i_lsu_rresp  in  2  bus response
- o_rf_gpr_wen  out  1  register file write enable
- o_rf_rd_id  out  5  write address
- o_rf_rd  out  XLEN  write data
- o_wbu_done  out  1  commit pulse to IFU
- o_wbu_pc_next  out  XLEN  next PC, valid with done
- o_wbu_err  out  1  load fault, pulses with done

## Operation
- FSM states: IDLE, WAIT_LD, COMMIT.
- IDLE: o_exu_ready=1, o_lsu_rready=0.
  - On i_exu_valid, latch all i_exu_* fields.
  - If is_load, go to WAIT_LD; otherwise load i_exu_result into the data register and go to COMMIT.
- WAIT_LD: o_exu_ready=0, o_lsu_rready=1.
  - On i_lsu_rvalid, latch the formatted data and err, then go to COMMIT.
  - No timeout; the unit waits indefinitely.
- COMMIT, one cycle:
  - o_wbu_done=1.
  - o_rf_gpr_wen = wen & (rd_id!=0) & !err.
  - o_rf_rd_id and o_rf_rd come from the latched registers.
  - Next state is IDLE.
- Load formatting, lane = addr_lo:
  - LB (000): byte[lane], sign-extended.
  - LBU (100): byte[lane], zero-extended.
  - LH (001): halfword[addr_lo[1]], sign-extended.
  - LHU (101): halfword[addr_lo[1]], zero-extended.
  - LW (010): full word.
- err=1 on any of:
  - i_lsu_rresp != RESP_OKAY.
  - LH/LHU with addr_lo[0]=1.
  - LW with addr_lo != 0.
  - funct3 in {011, 110, 111}.
- On err, the GPR write is suppressed. done and pc_next still assert so the trap logic sees the fault.
- rd_id=0 never writes, but still commits.
- i_lsu_rvalid outside WAIT_LD is ignored; rready is low there.
- Reset at any cycle, including mid-WAIT_LD: state goes to IDLE and the pending instruction is discarded. A late rvalid after reset is ignored until a new load is accepted.

## Timing
- Reset values:
  - o_rf_gpr_wen=0, o_rf_rd_id=0, o_rf_rd=0.
  - o_wbu_done=0, o_wbu_err=0, o_wbu_pc_next=0.
  - o_lsu_rready=0.
  - o_exu_ready=1 (IDLE).
- Handshake completes on a clk edge where valid & ready are both high.
- Non-load accepted at edge N: COMMIT during cycle N..N+1, and the register file captures at edge N+1.
- Load: rvalid & rready at edge M gives COMMIT in the following cycle.
- Throughput: at most one instruction per 2 cycles. o_exu_ready=0 in WAIT_LD and COMMIT.
- All outputs decode from state and registers only. There is no combinational path from any input to any output.

## Structure
- Shared defines/package holds:
  - FSM state encodings.
  - Load funct3 constants (LB/LH/LW/LBU/LHU).
  - RESP_OKAY.
  - Existing RegBus, Reg_x0 and RST_VAL.
- Sub-module load_align: combinational lane select and extension. Inputs funct3, addr_lo, rdata; outputs data and misalign_err.

## Test plan
- ALU op, wen=1, rd=5, result=0x00001234, pc_next=0x80000004 -> next cycle gpr_wen=1, rd_id=5, rd=0x00001234, done=1, pc_next=0x80000004; ready returns 1 the following cycle.
- Non-load with rd=0, result=0xDEADBEEF -> done=1, gpr_wen=0.
- LB with addr_lo=3, rdata=0x80FF0000 after 3 wait cycles -> rd=0xFFFFFF80. Same case as LBU -> rd=0x00000080. Commit is one cycle after rvalid.
- LH with addr_lo=2, rdata=0x8001_7FFF -> rd=0xFFFF8001. LH with addr_lo=1 -> err=1, gpr_wen=0, done=1.
- LW with rresp=2'b10 -> err=1, no GPR write. rvalid pulsed while in IDLE -> ignored, rready stays 0.
- Load accepted, rst asserted for 1 cycle in WAIT_LD, then rvalid -> no write, no done; outputs at reset values; ready=1.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared definitions for the write-back unit.
//   - wb_state_e : write-back FSM states
//   - F3_*       : load funct3 encodings
//   - RESP_OKAY  : bus response code for a successful transfer
//   - RegBus, Reg_x0, RST_VAL : register-file bus type, zero register id,
//                  asserted level of the synchronous reset
package wb_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LD = 2'd1,
        ST_COMMIT  = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic [31:0] RegBus;
    localparam logic [4:0] Reg_x0  = 5'd0;
    localparam logic       RST_VAL = 1'b1;

endpackage

// File: rtl/wb_unit_load_align.sv
// load_align: combinational lane select and sign/zero extension of a load.
//   i_funct3       : load type (funct3 encoding)
//   i_addr_lo      : byte address bits [1:0]
//   i_rdata        : raw 32-bit word returned by the bus
//   o_data         : formatted load result, XLEN wide
//   o_misalign_err : misaligned access or unsupported funct3
module load_align
    import wb_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  RegBus           i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Unsupported funct3 values are reported on the same error line as a
    // misalignment; the write-back unit treats both as a load fault.
    always_comb begin
        o_data         = '0;
        o_misalign_err = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                o_data         = {{(XLEN-16){w_half[15]}}, w_half};
                o_misalign_err = i_addr_lo[0];
            end
            F3_LHU: begin
                o_data         = {{(XLEN-16){1'b0}}, w_half};
                o_misalign_err = i_addr_lo[0];
            end
            F3_LW: begin
                o_data         = {{(XLEN-32){i_rdata[31]}}, i_rdata};
                o_misalign_err = (i_addr_lo != 2'd0);
            end
            default: o_misalign_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: write-back stage of the multi-cycle NPC core.
//   EXU side : i_exu_valid / o_exu_ready handshake plus instruction fields
//   LSU side : i_lsu_rvalid / o_lsu_rready handshake, i_lsu_rdata, i_lsu_rresp
//   RF side  : o_rf_gpr_wen, o_rf_rd_id, o_rf_rd (one-cycle write at commit)
//   IFU side : o_wbu_done pulse with o_wbu_pc_next and o_wbu_err
// Every output is a register; no input reaches an output combinationally.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [1:0] RESP_OKAY = wb_unit_pkg::RESP_OKAY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_exu_valid,
    output logic            o_exu_ready,
    input  logic            i_exu_wen,
    input  logic [4:0]      i_exu_rd_id,
    input  logic            i_exu_is_load,
    input  logic [2:0]      i_exu_ld_funct3,
    input  logic [1:0]      i_exu_addr_lo,
    input  logic [XLEN-1:0] i_exu_result,
    input  logic [XLEN-1:0] i_exu_pc_next,
    input  logic            i_lsu_rvalid,
    output logic            o_lsu_rready,
    input  logic [31:0]     i_lsu_rdata,
    input  logic [1:0]      i_lsu_rresp,
    output logic            o_rf_gpr_wen,
    output logic [4:0]      o_rf_rd_id,
    output logic [XLEN-1:0] o_rf_rd,
    output logic            o_wbu_done,
    output logic [XLEN-1:0] o_wbu_pc_next,
    output logic            o_wbu_err
);

    wb_state_e       r_state;
    logic            r_exu_ready;
    logic            r_lsu_rready;
    logic            r_wen;
    logic [4:0]      r_rd_id;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_pc_next;
    logic            r_gpr_wen;
    logic            r_done;
    logic            r_err;

    logic [XLEN-1:0] w_ld_data;
    logic            w_misalign;
    logic            w_ld_err;

    load_align #(.XLEN(XLEN)) u_align (
        .i_funct3       (r_funct3),
        .i_addr_lo      (r_addr_lo),
        .i_rdata        (i_lsu_rdata),
        .o_data         (w_ld_data),
        .o_misalign_err (w_misalign)
    );

    assign w_ld_err = w_misalign | (i_lsu_rresp != RESP_OKAY);

    // Handshake outputs are registered alongside the state so they change
    // on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (rst == RST_VAL) begin
            r_state      <= ST_IDLE;
            r_exu_ready  <= 1'b1;
            r_lsu_rready <= 1'b0;
            r_wen        <= 1'b0;
            r_rd_id      <= Reg_x0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_data       <= '0;
            r_pc_next    <= '0;
            r_gpr_wen    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_exu_valid) begin
                        r_wen       <= i_exu_wen;
                        r_rd_id     <= i_exu_rd_id;
                        r_funct3    <= i_exu_ld_funct3;
                        r_addr_lo   <= i_exu_addr_lo;
                        r_pc_next   <= i_exu_pc_next;
                        r_exu_ready <= 1'b0;
                        if (i_exu_is_load) begin
                            r_lsu_rready <= 1'b1;
                            r_state      <= ST_WAIT_LD;
                        end else begin
                            r_data    <= i_exu_result;
                            r_err     <= 1'b0;
                            r_done    <= 1'b1;
                            r_gpr_wen <= i_exu_wen & (i_exu_rd_id != Reg_x0);
                            r_state   <= ST_COMMIT;
                        end
                    end
                end
                ST_WAIT_LD: begin
                    if (i_lsu_rvalid) begin
                        r_data       <= w_ld_data;
                        r_err        <= w_ld_err;
                        r_lsu_rready <= 1'b0;
                        r_done       <= 1'b1;
                        r_gpr_wen    <= r_wen & (r_rd_id != Reg_x0) & ~w_ld_err;
                        r_state      <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_done      <= 1'b0;
                    r_gpr_wen   <= 1'b0;
                    r_err       <= 1'b0;
                    r_exu_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_exu_ready  <= 1'b1;
                    r_lsu_rready <= 1'b0;
                    r_done       <= 1'b0;
                    r_gpr_wen    <= 1'b0;
                    r_err        <= 1'b0;
                end
            endcase
        end
    end

    assign o_exu_ready   = r_exu_ready;
    assign o_lsu_rready  = r_lsu_rready;
    assign o_rf_gpr_wen  = r_gpr_wen;
    assign o_rf_rd_id    = r_rd_id;
    assign o_rf_rd       = r_data;
    assign o_wbu_done    = r_done;
    assign o_wbu_pc_next = r_pc_next;
    assign o_wbu_err     = r_err;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: self-checking bench for wb_unit. A vector table drives
// instructions; expected commits go into a scoreboard queue when an
// instruction is issued and are popped when o_wbu_done appears. Hand-written
// sequences cover rvalid in IDLE and reset in the middle of a load.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exu_valid;
    logic        o_exu_ready;
    logic        i_exu_wen;
    logic [4:0]  i_exu_rd_id;
    logic        i_exu_is_load;
    logic [2:0]  i_exu_ld_funct3;
    logic [1:0]  i_exu_addr_lo;
    logic [31:0] i_exu_result;
    logic [31:0] i_exu_pc_next;
    logic        i_lsu_rvalid;
    logic        o_lsu_rready;
    logic [31:0] i_lsu_rdata;
    logic [1:0]  i_lsu_rresp;
    logic        o_rf_gpr_wen;
    logic [4:0]  o_rf_rd_id;
    logic [31:0] o_rf_rd;
    logic        o_wbu_done;
    logic [31:0] o_wbu_pc_next;
    logic        o_wbu_err;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32), .RESP_OKAY(2'b00)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_exu_valid     (i_exu_valid),
        .o_exu_ready     (o_exu_ready),
        .i_exu_wen       (i_exu_wen),
        .i_exu_rd_id     (i_exu_rd_id),
        .i_exu_is_load   (i_exu_is_load),
        .i_exu_ld_funct3 (i_exu_ld_funct3),
        .i_exu_addr_lo   (i_exu_addr_lo),
        .i_exu_result    (i_exu_result),
        .i_exu_pc_next   (i_exu_pc_next),
        .i_lsu_rvalid    (i_lsu_rvalid),
        .o_lsu_rready    (o_lsu_rready),
        .i_lsu_rdata     (i_lsu_rdata),
        .i_lsu_rresp     (i_lsu_rresp),
        .o_rf_gpr_wen    (o_rf_gpr_wen),
        .o_rf_rd_id      (o_rf_rd_id),
        .o_rf_rd         (o_rf_rd),
        .o_wbu_done      (o_wbu_done),
        .o_wbu_pc_next   (o_wbu_pc_next),
        .o_wbu_err       (o_wbu_err)
    );

    typedef struct {
        logic        is_load;
        logic        wen;
        logic [4:0]  rd_id;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          waits;
        logic        exp_wen;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd_id;
        logic [31:0] rd;
        logic        err;
        logic [31:0] pc;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic wen, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [1:0] lo,
                                input logic [31:0] res, input logic [31:0] pc,
                                input logic [31:0] rdata, input logic [1:0] rresp,
                                input int waits, input logic ewen,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.is_load = ld;   v.wen = wen;      v.rd_id = rd;
        v.f3 = f3;        v.lo = lo;        v.result = res;
        v.pc = pc;        v.rdata = rdata;  v.rresp = rresp;
        v.waits = waits;  v.exp_wen = ewen; v.exp_rd = erd;
        v.exp_err = eerr;
        return v;
    endfunction

    task automatic idle_inputs();
        i_exu_valid     = 1'b0;
        i_exu_wen       = 1'b0;
        i_exu_rd_id     = 5'd0;
        i_exu_is_load   = 1'b0;
        i_exu_ld_funct3 = 3'd0;
        i_exu_addr_lo   = 2'd0;
        i_exu_result    = 32'd0;
        i_exu_pc_next   = 32'd0;
        i_lsu_rvalid    = 1'b0;
        i_lsu_rdata     = 32'd0;
        i_lsu_rresp     = 2'b00;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gpr_wen"}, {31'd0, o_rf_gpr_wen}, 32'd0);
        chk({tag, "_rd_id"},   {27'd0, o_rf_rd_id},   32'd0);
        chk({tag, "_rd"},      o_rf_rd,               32'd0);
        chk({tag, "_done"},    {31'd0, o_wbu_done},   32'd0);
        chk({tag, "_err"},     {31'd0, o_wbu_err},    32'd0);
        chk({tag, "_pc_next"}, o_wbu_pc_next,         32'd0);
        chk({tag, "_rready"},  {31'd0, o_lsu_rready}, 32'd0);
        chk({tag, "_ready"},   {31'd0, o_exu_ready},  32'd1);
    endtask

    // Called with clk low (just after a negedge).
    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        exp_t e;
        k = 0;
        while (!o_exu_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_ready_before_issue", idx), {31'd0, o_exu_ready}, 32'd1);

        i_exu_valid     = 1'b1;
        i_exu_wen       = v.wen;
        i_exu_rd_id     = v.rd_id;
        i_exu_is_load   = v.is_load;
        i_exu_ld_funct3 = v.f3;
        i_exu_addr_lo   = v.lo;
        i_exu_result    = v.result;
        i_exu_pc_next   = v.pc;
        e.wen   = v.exp_wen;
        e.rd_id = v.rd_id;
        e.rd    = v.exp_rd;
        e.err   = v.exp_err;
        e.pc    = v.pc;
        sb.push_back(e);
        @(negedge clk);
        i_exu_valid   = 1'b0;
        i_exu_result  = 32'hA5A5A5A5;
        i_exu_rd_id   = 5'd31;

        if (v.is_load) begin
            chk($sformatf("v%0d_wait_rready", idx), {31'd0, o_lsu_rready}, 32'd1);
            chk($sformatf("v%0d_wait_ready", idx),  {31'd0, o_exu_ready},  32'd0);
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                chk($sformatf("v%0d_no_early_done%0d", idx, w), {31'd0, o_wbu_done}, 32'd0);
            end
            i_lsu_rvalid = 1'b1;
            i_lsu_rdata  = v.rdata;
            i_lsu_rresp  = v.rresp;
            @(negedge clk);
            i_lsu_rvalid = 1'b0;
            i_lsu_rdata  = 32'h5A5A5A5A;
            i_lsu_rresp  = 2'b11;
        end

        k = 0;
        while (!o_wbu_done && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_done_latency", idx), k, 32'd0);
        if (o_wbu_done && sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d_gpr_wen", idx), {31'd0, o_rf_gpr_wen}, {31'd0, e.wen});
            chk($sformatf("v%0d_rd_id", idx),   {27'd0, o_rf_rd_id},   {27'd0, e.rd_id});
            chk($sformatf("v%0d_err", idx),     {31'd0, o_wbu_err},    {31'd0, e.err});
            chk($sformatf("v%0d_pc_next", idx), o_wbu_pc_next,         e.pc);
            chk($sformatf("v%0d_commit_ready", idx), {31'd0, o_exu_ready}, 32'd0);
            if (!e.err)
                chk($sformatf("v%0d_rd", idx), o_rf_rd, e.rd);
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, o_wbu_done},   32'd0);
        chk($sformatf("v%0d_wen_pulse", idx),  {31'd0, o_rf_gpr_wen}, 32'd0);
        chk($sformatf("v%0d_ready_back", idx), {31'd0, o_exu_ready},  32'd1);
    endtask

    initial begin
        //           ld wen rd     f3      lo     result        pc            rdata         rresp  w  ewen erd           eerr
        vecs[0]  = mk(0, 1, 5'd5,  3'b000, 2'd0, 32'h00001234, 32'h80000004, 32'h0,        2'b00, 0, 1, 32'h00001234, 0);
        vecs[1]  = mk(0, 1, 5'd0,  3'b000, 2'd0, 32'hDEADBEEF, 32'h80000008, 32'h0,        2'b00, 0, 0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 1, 5'd7,  3'b000, 2'd3, 32'h0,        32'h8000000C, 32'h80FF0000, 2'b00, 3, 1, 32'hFFFFFF80, 0);
        vecs[3]  = mk(1, 1, 5'd8,  3'b100, 2'd3, 32'h0,        32'h80000010, 32'h80FF0000, 2'b00, 3, 1, 32'h00000080, 0);
        vecs[4]  = mk(1, 1, 5'd9,  3'b001, 2'd2, 32'h0,        32'h80000014, 32'h80017FFF, 2'b00, 1, 1, 32'hFFFF8001, 0);
        vecs[5]  = mk(1, 1, 5'd10, 3'b001, 2'd1, 32'h0,        32'h80000018, 32'h80017FFF, 2'b00, 0, 0, 32'h0,        1);
        vecs[6]  = mk(1, 1, 5'd11, 3'b010, 2'd0, 32'h0,        32'h8000001C, 32'h12345678, 2'b10, 2, 0, 32'h0,        1);
        vecs[7]  = mk(1, 1, 5'd12, 3'b101, 2'd0, 32'h0,        32'h80000020, 32'h80017FFF, 2'b00, 0, 1, 32'h00007FFF, 0);
        vecs[8]  = mk(1, 1, 5'd13, 3'b010, 2'd0, 32'h0,        32'h80000024, 32'h12345678, 2'b00, 0, 1, 32'h12345678, 0);
        vecs[9]  = mk(1, 1, 5'd14, 3'b000, 2'd1, 32'h0,        32'h80000028, 32'h0000A500, 2'b00, 1, 1, 32'hFFFFFFA5, 0);
        vecs[10] = mk(1, 1, 5'd15, 3'b010, 2'd2, 32'h0,        32'h8000002C, 32'h12345678, 2'b00, 0, 0, 32'h0,        1);
        vecs[11] = mk(1, 1, 5'd16, 3'b011, 2'd0, 32'h0,        32'h80000030, 32'h12345678, 2'b00, 0, 0, 32'h0,        1);
        vecs[12] = mk(1, 0, 5'd3,  3'b101, 2'd2, 32'h0,        32'h80000034, 32'hBEEF0000, 2'b00, 0, 0, 32'h0000BEEF, 0);
        vecs[13] = mk(1, 1, 5'd0,  3'b010, 2'd0, 32'h0,        32'h80000038, 32'hCAFEF00D, 2'b00, 1, 0, 32'hCAFEF00D, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // rvalid while idle must be ignored.
        i_lsu_rvalid = 1'b1;
        i_lsu_rdata  = 32'h11111111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("idle_rvalid_rready%0d", c), {31'd0, o_lsu_rready}, 32'd0);
            chk($sformatf("idle_rvalid_done%0d", c),   {31'd0, o_wbu_done},   32'd0);
            chk($sformatf("idle_rvalid_wen%0d", c),    {31'd0, o_rf_gpr_wen}, 32'd0);
            chk($sformatf("idle_rvalid_ready%0d", c),  {31'd0, o_exu_ready},  32'd1);
        end
        i_lsu_rvalid = 1'b0;

        // Reset while a load is outstanding discards it.
        i_exu_valid     = 1'b1;
        i_exu_wen       = 1'b1;
        i_exu_rd_id     = 5'd21;
        i_exu_is_load   = 1'b1;
        i_exu_ld_funct3 = 3'b010;
        i_exu_addr_lo   = 2'd0;
        i_exu_pc_next   = 32'h80000100;
        @(negedge clk);
        idle_inputs();
        chk("rstld_in_wait_rready", {31'd0, o_lsu_rready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rstld");
        i_lsu_rvalid = 1'b1;
        i_lsu_rdata  = 32'h77777777;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rstld_late_done%0d", c),   {31'd0, o_wbu_done},   32'd0);
            chk($sformatf("rstld_late_wen%0d", c),    {31'd0, o_rf_gpr_wen}, 32'd0);
            chk($sformatf("rstld_late_rready%0d", c), {31'd0, o_lsu_rready}, 32'd0);
            chk($sformatf("rstld_late_ready%0d", c),  {31'd0, o_exu_ready},  32'd1);
            chk($sformatf("rstld_late_rd%0d", c),     o_rf_rd,               32'd0);
        end
        i_lsu_rvalid = 1'b0;

        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
